// File: rtl/burst_mem_ctrl.sv
// Burst memory controller: arbitrates write/read burst requests onto a single-port
// word memory, streaming write beats in and registered read beats out.
module burst_mem_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int LEN_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_req,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_ack,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic              o_done,
  output logic              o_busy
);

  // state | meaning
  // IDLE  | sample requests, arbitrate, latch addr/len
  // WR    | accept write beats while beats remain
  // RD    | stream read beats out through the output register
  // DONE  | one-cycle completion pulse, then back to IDLE
  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [LEN_W-1:0]  rem_q;
  logic              last_rd_q;
  logic              ack_q;
  logic              done_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic              rem_nz;
  logic              wr_fire;
  logic              rd_take;
  logic              rd_load;
  logic              grant_wr;
  logic              grant_rd;
  logic [ADDR_W-1:0] ptr_d;
  logic [LEN_W-1:0]  rem_d;

  assign rem_nz     = (rem_q != '0);
  assign o_wr_ready = (state_q == S_WR) && rem_nz;
  assign wr_fire    = o_wr_ready && i_wr_valid;
  assign rd_take    = rd_valid_q && i_rd_ready;
  assign rd_load    = (state_q == S_RD) && rem_nz && (!rd_valid_q || i_rd_ready);
  // On a tie, grant the type opposite to the last grant
  assign grant_wr   = i_wr_req && (!i_rd_req || last_rd_q);
  assign grant_rd   = i_rd_req && !grant_wr;
  assign ptr_d      = ptr_q + ADDR_W'(1);
  assign rem_d      = rem_q - LEN_W'(1);

  assign o_ack      = ack_q;
  assign o_done     = done_q;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_data_q;
  assign o_busy     = (state_q != S_IDLE);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      last_rd_q  <= 1'b1;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_wr || grant_rd) begin
            ack_q     <= 1'b1;
            ptr_q     <= i_addr;
            rem_q     <= i_len;
            last_rd_q <= grant_rd;
            if (i_len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= grant_wr ? S_WR : S_RD;
            end
          end
        end
        S_WR: begin
          if (wr_fire) begin
            ptr_q <= ptr_d;
            rem_q <= rem_d;
            if (rem_q == LEN_W'(1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (rd_load) begin
            rd_data_q  <= mem_q[ptr_q];
            rd_valid_q <= 1'b1;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
          end else if (rd_take) begin
            rd_valid_q <= 1'b0;
          end
          // Final beat handed off with nothing left to load
          if (rd_take && !rem_nz) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Memory has no reset so contents survive an aborted burst
  always_ff @(posedge i_clk) begin
    if (wr_fire) mem_q[ptr_q] <= i_wr_data;
  end

endmodule

// File: tb/tb_burst_mem_ctrl.sv
// Directed bench for burst_mem_ctrl: inputs change and outputs are sampled on the
// falling clock edge, away from the rising active edge.
module tb_burst_mem_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset, i_wr_req, i_rd_req, i_wr_valid, i_rd_ready;
  logic [5:0] i_addr;
  logic [3:0] i_len;
  logic [7:0] i_wr_data;
  logic       o_ack, o_wr_ready, o_rd_valid, o_done, o_busy;
  logic [7:0] o_rd_data;

  int errors = 0;
  int checks = 0;
  logic [7:0] wdat [0:15];
  logic [7:0] rexp [0:15];
  logic [3:0] exp_w;

  burst_mem_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_wr_req(i_wr_req), .i_rd_req(i_rd_req),
    .i_addr(i_addr), .i_len(i_len), .o_ack(o_ack), .i_wr_data(i_wr_data),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .o_rd_data(o_rd_data),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_done(o_done), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ack"}, o_ack, 0);
    chk({tag, "_wr_ready"}, o_wr_ready, 0);
    chk({tag, "_rd_valid"}, o_rd_valid, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_rd_data"}, o_rd_data, 0);
  endtask

  // Write burst of wdat[0..l-1]; valid is dropped for one cycle at beat stall_k
  task automatic wr_burst(input logic [5:0] a, input logic [3:0] l, input int stall_k);
    @(negedge i_clk);
    i_wr_req = 1'b1; i_addr = a; i_len = l; i_wr_valid = 1'b0;
    @(negedge i_clk);
    chk("wr_ack", o_ack, 1);
    chk("wr_busy", o_busy, 1);
    i_wr_req = 1'b0;
    for (int k = 0; k < int'(l); k++) begin
      if (k > 0) @(negedge i_clk);
      if (k == stall_k) begin
        i_wr_valid = 1'b0;
        @(negedge i_clk);
        chk("wr_stall_ready", o_wr_ready, 1);
      end
      chk("wr_ready", o_wr_ready, 1);
      chk("wr_no_done", o_done, 0);
      i_wr_data = wdat[k]; i_wr_valid = 1'b1;
    end
    @(negedge i_clk);
    i_wr_valid = 1'b0;
    chk("wr_done", o_done, 1);
    chk("wr_ready_off", o_wr_ready, 0);
    @(negedge i_clk);
    chk("wr_done_once", o_done, 0);
    chk("wr_idle", o_busy, 0);
  endtask

  // Read burst expecting rexp[0..l-1]; ready held low for 2 cycles at beat stall_k
  task automatic rd_burst(input logic [5:0] a, input logic [3:0] l, input int stall_k);
    @(negedge i_clk);
    i_rd_req = 1'b1; i_addr = a; i_len = l; i_rd_ready = 1'b1;
    @(negedge i_clk);
    chk("rd_ack", o_ack, 1);
    chk("rd_first_not_yet", o_rd_valid, 0);
    i_rd_req = 1'b0;
    for (int k = 0; k < int'(l); k++) begin
      @(negedge i_clk);
      chk("rd_valid", o_rd_valid, 1);
      chk("rd_data", o_rd_data, rexp[k]);
      if (k == stall_k) begin
        i_rd_ready = 1'b0;
        repeat (2) begin
          @(negedge i_clk);
          chk("rd_hold_valid", o_rd_valid, 1);
          chk("rd_hold_data", o_rd_data, rexp[k]);
        end
        i_rd_ready = 1'b1;
      end
    end
    @(negedge i_clk);
    chk("rd_done", o_done, 1);
    chk("rd_valid_drop", o_rd_valid, 0);
    @(negedge i_clk);
    chk("rd_done_once", o_done, 0);
    chk("rd_idle", o_busy, 0);
  endtask

  initial begin
    i_reset = 1'b0; i_wr_req = 1'b0; i_rd_req = 1'b0; i_wr_valid = 1'b0;
    i_rd_ready = 1'b0; i_addr = '0; i_len = '0; i_wr_data = '0;
    repeat (3) @(negedge i_clk);
    chk_outs_zero("reset");
    i_reset = 1'b1;

    // Both requests held: grants alternate W,R,W,R starting with W
    i_addr = 6'd20; i_len = 4'd1; i_wr_data = 8'h55; i_wr_valid = 1'b1; i_rd_ready = 1'b1;
    i_wr_req = 1'b1; i_rd_req = 1'b1;
    exp_w = 4'b0101;
    for (int g = 0; g < 4; g++) begin
      @(negedge i_clk);
      for (int c = 0; c < 10 && !o_ack; c++) @(negedge i_clk);
      chk("arb_ack", o_ack, 1);
      chk("arb_is_write", o_wr_ready, exp_w[g]);
    end
    i_wr_req = 1'b0; i_rd_req = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("arb_idle", o_busy, 0);
    i_wr_valid = 1'b0;

    // Write addr 5, len 3, then read back, then read with a stall on beat 2
    wdat[0] = 8'hA1; wdat[1] = 8'hA2; wdat[2] = 8'hA3;
    wr_burst(6'd5, 4'd3, -1);
    rexp[0] = 8'hA1; rexp[1] = 8'hA2; rexp[2] = 8'hA3;
    rd_burst(6'd5, 4'd3, -1);
    rd_burst(6'd5, 4'd3, 1);

    // Wrap across the top address, with one write stall
    wdat[0] = 8'hB0; wdat[1] = 8'hB1; wdat[2] = 8'hB2; wdat[3] = 8'hB3;
    wr_burst(6'd62, 4'd4, 2);
    rexp[0] = 8'hB0; rexp[1] = 8'hB1; rexp[2] = 8'hB2; rexp[3] = 8'hB3;
    rd_burst(6'd62, 4'd4, -1);
    rexp[0] = 8'hB2; rexp[1] = 8'hB3;
    rd_burst(6'd0, 4'd2, -1);
    rexp[0] = 8'h55;
    rd_burst(6'd20, 4'd1, -1);

    // Zero-length burst: ack and done, no beats
    @(negedge i_clk);
    i_wr_req = 1'b1; i_addr = 6'd10; i_len = 4'd0;
    @(negedge i_clk);
    i_wr_req = 1'b0;
    chk("len0_ack", o_ack, 1);
    chk("len0_done", o_done, 1);
    chk("len0_no_ready", o_wr_ready, 0);
    @(negedge i_clk);
    chk("len0_done_once", o_done, 0);
    chk("len0_idle", o_busy, 0);

    // Reset after 2 of 5 write beats
    @(negedge i_clk);
    i_wr_req = 1'b1; i_addr = 6'd40; i_len = 4'd5;
    @(negedge i_clk);
    i_wr_req = 1'b0;
    chk("abort_ack", o_ack, 1);
    i_wr_data = 8'hC0; i_wr_valid = 1'b1;
    @(negedge i_clk);
    i_wr_data = 8'hC1;
    @(negedge i_clk);
    chk("abort_ready_before", o_wr_ready, 1);
    i_wr_data = 8'hC2;
    i_reset = 1'b0;
    #1;
    chk_outs_zero("abort");
    repeat (2) begin
      @(negedge i_clk);
      chk("abort_no_done", o_done, 0);
    end
    i_wr_valid = 1'b0;
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("abort_post_done", o_done, 0);
    chk("abort_post_idle", o_busy, 0);
    rexp[0] = 8'hC0; rexp[1] = 8'hC1;
    rd_burst(6'd40, 4'd2, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/burst_mem_ctrl.md
BURST_MEM_CTRL -- requirements
Module: burst_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 6, meaning address width; memory depth is 2**ADDR_W words.
REQ-003 The block SHALL have parameter LEN_W, default 4, meaning burst-length field width; the maximum burst is 2**LEN_W-1 beats.
REQ-004 The block SHALL have port i_clk  in  1  clock; all state changes on its rising edge.
REQ-005 The block SHALL have port i_reset  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port i_wr_req  in  1  level write-burst request.
REQ-007 The block SHALL have port i_rd_req  in  1  level read-burst request.
REQ-008 The block SHALL have port i_addr  in  ADDR_W  burst start address, sampled at grant.
REQ-009 The block SHALL have port i_len  in  LEN_W  burst beat count, sampled at grant.
REQ-010 The block SHALL have port o_ack  out  1  one-cycle pulse: request granted.
REQ-011 The block SHALL have port i_wr_data  in  DATA_W  write beat data.
REQ-012 The block SHALL have port i_wr_valid  in  1  write beat valid.
REQ-013 The block SHALL have port o_wr_ready  out  1  write beat accept.
REQ-014 The block SHALL have port o_rd_data  out  DATA_W  read beat data, registered.
REQ-015 The block SHALL have port o_rd_valid  out  1  read beat valid, registered.
REQ-016 The block SHALL have port i_rd_ready  in  1  read beat accept.
REQ-017 The block SHALL have port o_done  out  1  one-cycle pulse: burst complete.
REQ-018 The block SHALL have port o_busy  out  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, WR, RD and DONE, and SHALL occupy IDLE after reset.
REQ-020 In IDLE, requests SHALL be sampled; if only one request is high, that request SHALL be granted.
REQ-021 If both requests are high in IDLE, the request opposite to the last granted type SHALL be granted; write wins the first tie after reset.
REQ-022 On grant, o_ack SHALL be 1 in the next cycle only, and i_addr and i_len SHALL be latched.
REQ-023 On grant, the FSM SHALL move to WR or RD, or to DONE if i_len==0.
REQ-024 Requests SHALL be ignored outside IDLE.
REQ-025 In WR, o_wr_ready SHALL be 1 combinationally while remaining beats>0.
REQ-026 Each cycle with i_wr_valid&o_wr_ready SHALL write mem[ptr]<=i_wr_data, increment ptr, and decrement the remaining count.
REQ-027 If i_wr_valid is low in WR, the block SHALL stall with no write.
REQ-028 In RD, o_rd_valid/o_rd_data SHALL load mem[ptr] whenever remaining beats>0 and (~o_rd_valid|i_rd_ready), incrementing ptr on each load.
REQ-029 The first read beat SHALL be valid 1 cycle after entry to RD.
REQ-030 Full throughput (1 beat/cycle) SHALL be sustained while i_rd_ready=1.
REQ-031 While o_rd_valid=1 and i_rd_ready=0, o_rd_data and o_rd_valid SHALL hold unchanged.
REQ-032 o_rd_valid SHALL drop after the last beat is accepted if no further beat is loaded.
REQ-033 ptr SHALL wrap modulo 2**ADDR_W; a burst crossing the top address SHALL continue at address 0.
REQ-034 The FSM SHALL transition WR->DONE on the cycle the final write beat is accepted.
REQ-035 The FSM SHALL transition RD->DONE on the cycle the final read beat is accepted (o_rd_valid&i_rd_ready with remaining=0).
REQ-036 In DONE, o_done SHALL be 1 for one cycle, followed by DONE->IDLE.
REQ-037 Consecutive grants SHALL therefore be separated by at least one IDLE cycle.
REQ-038 Arithmetic SHALL be unsigned; the remaining counter is LEN_W bits and SHALL never underflow.

Reset
REQ-039 While i_reset=0, o_ack, o_wr_ready, o_rd_valid, o_done and o_busy SHALL be 0.
REQ-040 While i_reset=0, o_rd_data SHALL be 0, the FSM SHALL be in IDLE, ptr and the counter SHALL be 0, and last-grant SHALL be "read" so that write wins the next tie.
REQ-041 Reset asserted mid-burst SHALL abort the burst immediately with no o_done; beats already written SHALL remain in memory.
REQ-042 Memory contents SHALL not be cleared by reset.

Verification
REQ-043 A bench SHALL cover: write req, addr=5, len=3, data A1/A2/A3 with valid held high -> o_ack pulse, 3 cycles of o_wr_ready, mem[5..7]=A1..A3, o_done once.
REQ-044 A bench SHALL cover: read req, addr=5, len=3, i_rd_ready=1 -> o_rd_valid for 3 consecutive cycles with A1,A2,A3, then o_done.
REQ-045 A bench SHALL cover: read with i_rd_ready low 2 cycles on beat 2 -> beat-2 data held stable, no beat lost or duplicated.
REQ-046 A bench SHALL cover: wr_req and rd_req both high repeatedly -> grants alternate W,R,W,R; the first grant after reset is W.
REQ-047 A bench SHALL cover: write addr=62, len=4 (ADDR_W=6) -> mem[62],mem[63],mem[0],mem[1] written; len=0 -> o_ack then o_done, no beats.
REQ-048 A bench SHALL cover: reset asserted after 2 of 5 write beats -> outputs 0 asynchronously, first 2 words retained, no o_done.
